// File: rtl/elevator_request_scheduler.sv
// SCAN-ordered elevator call scheduler: latches floor calls, dispatches one target at a time,
// and holds the door open for a fixed dwell after each stop.
//
// state    | meaning
// IDLE     | waiting; serve the current floor locally or pick the next SCAN target
// DISPATCH | target_valid high, waiting for target_ready
// TRAVEL   | car moving to target_floor; no retargeting
// DWELL    | door open, dwell counter running down
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 10,
    parameter int DWELL_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_in,
    input  logic [3:0]            car_floor,
    input  logic                  car_idle,
    output logic [3:0]            target_floor,
    output logic                  target_valid,
    input  logic                  target_ready,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPATCH = 2'd1;
    localparam logic [1:0] ST_TRAVEL   = 2'd2;
    localparam logic [1:0] ST_DWELL    = 2'd3;
    localparam logic [7:0] DWELL_LOAD  = 8'(DWELL_CYCLES);

    logic [1:0]            state;
    logic [7:0]            dwell_cnt;
    logic [NUM_FLOORS-1:0] car_onehot;
    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic                  at_car_pending;
    logic                  call_at_car;
    logic                  arrived;
    logic                  found_above;
    logic                  found_below;
    logic [3:0]            above_floor;
    logic [3:0]            below_floor;
    logic [3:0]            scan_floor;
    logic                  scan_dir;

    // An out-of-range car_floor matches no bit, so it never counts as a local stop.
    always_comb begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
            car_onehot[i] = (car_floor == 4'(i));
        end
    end

    assign at_car_pending = |(pending & car_onehot);
    assign call_at_car    = |(call_in & car_onehot);
    assign arrived        = car_idle && (car_floor == target_floor);

    always_comb begin
        found_above = 1'b0;
        found_below = 1'b0;
        above_floor = '0;
        below_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (4'(i) > car_floor)) begin
                found_above = 1'b1;
                above_floor = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (4'(i) < car_floor)) begin
                found_below = 1'b1;
                below_floor = 4'(i);
            end
        end
    end

    // Only the car's own floor pending (car not idle) falls through to car_floor.
    always_comb begin
        scan_floor = car_floor;
        scan_dir   = dir_up;
        if (dir_up) begin
            if (found_above) begin
                scan_floor = above_floor;
            end else if (found_below) begin
                scan_floor = below_floor;
                scan_dir   = 1'b0;
            end
        end else begin
            if (found_below) begin
                scan_floor = below_floor;
            end else if (found_above) begin
                scan_floor = above_floor;
                scan_dir   = 1'b1;
            end
        end
    end

    // Clear beats a same-cycle call because the car is standing at that floor.
    always_comb begin
        set_mask   = call_in;
        clear_mask = '0;
        case (state)
            ST_IDLE:   if (car_idle && at_car_pending) clear_mask = car_onehot;
            ST_TRAVEL: if (arrived) clear_mask = car_onehot;
            ST_DWELL:  set_mask = call_in & ~car_onehot;
            default:   clear_mask = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pending      <= '0;
            target_floor <= '0;
            dir_up       <= 1'b1;
            dwell_cnt    <= '0;
        end else begin
            pending <= (pending | set_mask) & ~clear_mask;
            case (state)
                ST_IDLE: begin
                    if (car_idle && at_car_pending) begin
                        dwell_cnt <= DWELL_LOAD;
                        state     <= ST_DWELL;
                    end else if (|pending) begin
                        target_floor <= scan_floor;
                        dir_up       <= scan_dir;
                        state        <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (target_ready) state <= ST_TRAVEL;
                end
                ST_TRAVEL: begin
                    if (arrived) begin
                        dwell_cnt <= DWELL_LOAD;
                        state     <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (call_at_car) begin
                        dwell_cnt <= DWELL_LOAD;
                    end else if (dwell_cnt <= 8'd1) begin
                        dwell_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        dwell_cnt <= dwell_cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign target_valid = (state == ST_DISPATCH);
    assign door_open    = (state == ST_DWELL);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios plus randomized call sets
// checked against a queue-based SCAN service-order model.
module tb_elevator_request_scheduler;

    localparam int NF = 10;
    localparam int DW = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NF-1:0] call_in;
    logic [3:0]    car_floor;
    logic          car_idle;
    logic [3:0]    target_floor;
    logic          target_valid;
    logic          target_ready;
    logic          door_open;
    logic          dir_up;
    logic [NF-1:0] pending;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt = 0;

    elevator_request_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .rst_n(rst_n), .call_in(call_in), .car_floor(car_floor),
        .car_idle(car_idle), .target_floor(target_floor), .target_valid(target_valid),
        .target_ready(target_ready), .door_open(door_open), .dir_up(dir_up),
        .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (target_valid === 1'b1) valid_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_calls(input logic [NF-1:0] m);
        call_in = m;
        tick();
        call_in = '0;
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (door_open === 1'b1 && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        target_ready = 1'b0;
        call_in      = NF'($urandom_range(1, (1 << NF) - 1));
        tick();
        chk("rst_pending", pending, 0);
        chk("rst_valid", target_valid, 0);
        chk("rst_door", door_open, 0);
        chk("rst_dir", dir_up, 1);
        chk("rst_busy", busy, 0);
        chk("rst_target", target_floor, 0);
        call_in = '0;
        rst_n   = 1'b1;
        tick();
        chk("rst_release_pending", pending, 0);
    endtask

    // Waits for a dispatch, holds ready low, accepts, drives the car there and times the door.
    task automatic serve(input int exp_floor, input bit exp_dir, input int hold);
        int waited;
        int n;
        waited = 0;
        while (target_valid !== 1'b1 && waited < 60) begin
            tick();
            waited++;
        end
        chk("dispatch_seen", target_valid, 1);
        chk("target_floor", target_floor, exp_floor);
        chk("dir_up", dir_up, exp_dir);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("valid_hold", target_valid, 1);
            chk("floor_hold", target_floor, exp_floor);
        end
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        chk("valid_drop", target_valid, 0);
        chk("travel_busy", busy, 1);
        car_floor = 4'(exp_floor);
        tick();
        chk("door_arrive", door_open, 1);
        count_door(n);
        chk("door_cycles", n, DW);
        chk("pending_clr", pending[exp_floor], 0);
    endtask

    // Reference SCAN: lowest call above in the up direction, else highest below and reverse.
    function automatic void scan_model(input logic [NF-1:0] p, input int car, input bit dir,
                                       output int tgt, output bit ndir);
        int above[$];
        int below[$];
        for (int i = 0; i < NF; i++) begin
            if (p[i] && i > car) above.push_back(i);
            if (p[i] && i < car) below.push_back(i);
        end
        tgt  = car;
        ndir = dir;
        if (dir) begin
            if (above.size() > 0) tgt = above[0];
            else if (below.size() > 0) begin tgt = below[below.size() - 1]; ndir = 1'b0; end
        end else begin
            if (below.size() > 0) tgt = below[below.size() - 1];
            else if (above.size() > 0) begin tgt = above[0]; ndir = 1'b1; end
        end
    endfunction

    logic [NF-1:0] m;
    int car, tgt, n, v0;
    bit dir, nd;

    initial begin
        rst_n        = 1'b0;
        call_in      = '0;
        car_floor    = 4'd0;
        car_idle     = 1'b1;
        target_ready = 1'b0;
        tick();
        tick();
        do_reset();

        // Basic dispatch to floor 5 with a stalled handshake
        car_floor = 4'd0;
        apply_calls(NF'(1) << 5);
        chk("pend_next_cycle", pending, 32'h20);
        chk("valid_n1", target_valid, 0);
        tick();
        chk("valid_n2", target_valid, 1);
        serve(5, 1'b1, 3);
        chk("after_031_pending", pending, 0);

        // Up sweep then reversal
        do_reset();
        car_floor = 4'd4;
        apply_calls((NF'(1) << 2) | (NF'(1) << 7));
        serve(7, 1'b1, 1);
        serve(2, 1'b0, 0);

        // Only a call below while heading up
        do_reset();
        car_floor = 4'd4;
        apply_calls(NF'(1) << 1);
        serve(1, 1'b0, 2);
        do_reset();

        // Re-call at current floor during dwell restarts the door timer
        car_floor = 4'd3;
        v0 = valid_cnt;
        apply_calls(NF'(1) << 3);
        tick();
        chk("dwell_local_door", door_open, 1);
        repeat (13) tick();
        chk("dwell_cnt2_door", door_open, 1);
        call_in = NF'(1) << 3;
        tick();
        call_in = '0;
        chk("recall_pending", pending, 0);
        count_door(n);
        chk("recall_door_cycles", n, DW);
        chk("recall_no_dispatch", valid_cnt - v0, 0);

        // Reset during travel
        do_reset();
        car_floor = 4'd0;
        apply_calls((NF'(1) << 2) | (NF'(1) << 8));
        tick();
        chk("r35_valid", target_valid, 1);
        chk("r35_floor", target_floor, 2);
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        chk("r35_busy", busy, 1);
        chk("r35_pending", pending, 32'h104);
        do_reset();

        // Local service at floor 6 without dispatch
        car_floor = 4'd6;
        v0 = valid_cnt;
        apply_calls(NF'(1) << 6);
        chk("local_pend", pending, 32'h40);
        tick();
        chk("local_door", door_open, 1);
        chk("local_busy", busy, 1);
        chk("local_pend_clr", pending, 0);
        count_door(n);
        chk("local_door_cycles", n, DW);
        chk("local_no_dispatch", valid_cnt - v0, 0);

        // Randomized call sets, including out-of-range car floors
        for (int it = 0; it < 25; it++) begin
            do_reset();
            m   = NF'($urandom_range(1, (1 << NF) - 1));
            car = $urandom_range(0, 11);
            dir = 1'b1;
            car_floor = 4'(car);
            v0 = valid_cnt;
            apply_calls(m);
            if (car < NF && m[car]) begin
                tick();
                chk("rnd_local_door", door_open, 1);
                chk("rnd_local_nodisp", valid_cnt - v0, 0);
                count_door(n);
                chk("rnd_local_cycles", n, DW);
                m[car] = 1'b0;
            end
            while (m != '0) begin
                scan_model(m, car, dir, tgt, nd);
                serve(tgt, nd, $urandom_range(0, 3));
                m[tgt] = 1'b0;
                car    = tgt;
                dir    = nd;
            end
            tick();
            tick();
            chk("rnd_final_pending", pending, 0);
            chk("rnd_final_busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
